// File: rtl/bit_serial_subtractor.sv
// ---------------------------------------------------------------------------
// bit_serial_subtractor
//
// Multi-cycle unsigned/two's-complement subtractor: diff = a - b, computed one
// bit per clock, LSB first, through a single full-subtractor cell and a
// registered borrow flip-flop. Operates as the SUB unit of the lab ALU behind
// a start/done handshake.
//
// Parameters:
//   WIDTH       operand/result width in bits (>= 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request, sampled only while idle
//   a, b        minuend / subtrahend, captured on the accepting edge
//   busy        high while bits are being processed
//   done        one-cycle pulse, result outputs valid
//   diff        a - b modulo 2^WIDTH
//   borrow_out  unsigned borrow (a < b)
//   overflow    two's-complement overflow of a - b
// ---------------------------------------------------------------------------
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   r;
    logic [CNT_W-1:0]   count;
    logic               br;
    logic               a_sign;
    logic               b_sign;

    // Full-subtractor cell acting on the current LSBs and the stored borrow.
    logic               a0;
    logic               b0;
    logic               d;
    logic               br_next;
    logic [WIDTH-1:0]   r_next;
    logic               ovf_next;

    always_comb begin
        a0       = a_sh[0];
        b0       = b_sh[0];
        d        = a0 ^ b0 ^ br;
        br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
        r_next   = {d, r[WIDTH-1:1]};
        // Overflow only possible when operand signs differ; it happened when
        // the result sign disagrees with the minuend sign.
        ovf_next = (a_sign != b_sign) && (r_next[WIDTH-1] != a_sign);
    end

    // Moore outputs decoded from the state register.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            r          <= '0;
            count      <= '0;
            br         <= 1'b0;
            a_sign     <= 1'b0;
            b_sign     <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        a_sign <= a[WIDTH-1];
                        b_sign <= b[WIDTH-1];
                        br     <= 1'b0;
                        count  <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r     <= r_next;
                    br    <= br_next;
                    count <= count + 1'b1;
                    // Result outputs update only here, so partial results
                    // never appear on diff.
                    if (count == LAST_BIT) begin
                        diff       <= r_next;
                        borrow_out <= br_next;
                        overflow   <= ovf_next;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
module tb_bit_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] prev_diff;

    always #5 clk = ~clk;

    bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output logic [WIDTH-1:0] d, output logic bo, output logic ov);
        int u;
        int s;
        u  = int'(x) - int'(y);
        d  = u[WIDTH-1:0];
        bo = (u < 0);
        s  = int'($signed(x)) - int'($signed(y));
        ov = (s > 127) || (s < -128);
    endtask

    // One full operation: start pulse, latency/busy tracking, result check.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input string tag);
        logic [WIDTH-1:0] ed;
        logic             ebo;
        logic             eov;
        int               done_k;
        int               busy_cnt;
        logic             stable;
        logic             overlap;
        model(x, y, ed, ebo, eov);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);                       // accepting edge E0
        done_k = -1; busy_cnt = 0; stable = 1'b1; overlap = 1'b0;
        for (int k = 0; k <= WIDTH + 4; k++) begin
            @(negedge clk);                   // sample after edge E_k
            if (k == 0) begin
                start = 1'b0;
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end
            if (done) begin
                done_k  = k;
                overlap = busy;
                break;
            end
            if (busy) busy_cnt++;
            if (diff !== prev_diff) stable = 1'b0;
        end
        check({tag, " latency"}, done_k, WIDTH);
        check({tag, " busy_cycles"}, busy_cnt, WIDTH);
        check({tag, " busy_with_done"}, overlap, 1'b0);
        check({tag, " diff_held"}, stable, 1'b1);
        check({tag, " diff"}, diff, ed);
        check({tag, " borrow"}, borrow_out, ebo);
        check({tag, " overflow"}, overflow, eov);
        @(negedge clk);
        check({tag, " done_pulse_width"}, done, 1'b0);
        prev_diff = ed;
    endtask

    initial begin
        logic [WIDTH-1:0] ed;
        logic             ebo;
        logic             eov;
        int               n_done;
        int               first_k;
        logic             diff_ok;
        logic             idle_gap;
        logic             re_accept;
        logic             done_in_rst;
        int               done_k;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        prev_diff = '0;
        repeat (3) @(negedge clk);
        check("reset diff", diff, 0);
        check("reset borrow", borrow_out, 0);
        check("reset overflow", overflow, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, "05-03");
        run_op(8'h03, 8'h05, "03-05");
        run_op(8'h00, 8'h00, "00-00");
        run_op(8'h80, 8'h01, "80-01");
        run_op(8'h7F, 8'hFF, "7F-FF");

        // start held high throughout; operands change mid-operation
        @(negedge clk);
        a = 8'h20; b = 8'h08; start = 1'b1;
        @(posedge clk);
        n_done = 0; first_k = -1; diff_ok = 1'b1; idle_gap = 1'b0; re_accept = 1'b0;
        for (int k = 0; k <= WIDTH + 2; k++) begin
            @(negedge clk);
            if (k == 2) begin a = 8'hC3; b = 8'h3C; end
            if (done) begin n_done++; first_k = k; end
            if (k < WIDTH && diff !== 8'h80) diff_ok = 1'b0;
            if (k == WIDTH && done) begin
                model(8'h20, 8'h08, ed, ebo, eov);
                check("hold diff", diff, ed);
            end
            if (k == WIDTH + 1) idle_gap = !busy && !done;
            if (k == WIDTH + 2) re_accept = busy;
        end
        check("hold one_done", n_done, 1);
        check("hold latency", first_k, WIDTH);
        check("hold diff_prev_kept", diff_ok, 1'b1);
        check("hold idle_gap", idle_gap, 1'b1);
        check("hold reaccept", re_accept, 1'b1);
        start = 1'b0;
        done_k = -1;
        for (int k = WIDTH + 3; k <= 2 * WIDTH + 6; k++) begin
            @(negedge clk);
            if (done) begin done_k = k; break; end
        end
        check("second latency", done_k, 2 * WIDTH + 2);
        model(8'hC3, 8'h3C, ed, ebo, eov);
        check("second diff", diff, ed);
        check("second borrow", borrow_out, ebo);
        check("second overflow", overflow, eov);
        prev_diff = ed;

        // asynchronous reset partway through an operation
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst diff", diff, 0);
        check("midrst borrow", borrow_out, 0);
        check("midrst overflow", overflow, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        done_in_rst = 1'b0;
        for (int k = 0; k < WIDTH + 2; k++) begin
            @(negedge clk);
            if (done) done_in_rst = 1'b1;
            if (k == 2) rst_n = 1'b1;
        end
        check("midrst no_done", done_in_rst, 1'b0);
        prev_diff = '0;
        run_op(8'h10, 8'h01, "10-01");

        for (int i = 0; i < 20; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
